// File: rtl/usr_pkg.sv
// usr_pkg: shared mode-select encodings and the default register width for usr
package usr_pkg;
  localparam int DEF_WIDTH = 4;
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell: one register bit with a hold/right/left/parallel mux; ports clk, rst (async active-low), sel, right, left, par, q
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       right,
  input  logic       left,
  input  logic       par,
  output logic       q
);
  logic d;
  always_comb d = (sel == SEL_SHR) ? right : (sel == SEL_SHL) ? left : (sel == SEL_LOAD) ? par : q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= d;
endmodule

// File: rtl/usr.sv
// usr: universal shift register (hold/shr/shl/load by sel); ports clk, rst (async active-low), in, sel, y
module usr
  import usr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] rn, ln;
  assign rn = {in[WIDTH-1], y[WIDTH-1:1]};
  assign ln = {y[WIDTH-2:0], in[0]};
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell u_cell (
      .clk(clk),
      .rst(rst),
      .sel(sel),
      .right(rn[i]),
      .left(ln[i]),
      .par(in[i]),
      .q(y[i])
    );
  end
endmodule

// File: tb/tb_usr.sv
// tb_usr: directed self-checking bench for usr
module tb_usr;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic [1:0] sel;
  logic [3:0] y;
  int checks = 0;
  int errors = 0;

  usr #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .in(in), .sel(sel), .y(y));

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    checks++;
    assert (y === exp) else begin
      errors++;
      $error("FAIL %s: y=%b expected %b", tag, y, exp);
    end
  endtask

  task automatic edge_check(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    rst = 1'b0;
    in  = 'x;
    sel = 'x;
    #5;
    check("reset_t5", 4'b0000);
    #6;
    check("reset_edge10_ignored", 4'b0000);
    #1;
    rst = 1'b1;
    in  = 4'b1011;
    sel = 2'b01;
    edge_check("shr1", 4'b1000);
    edge_check("shr2", 4'b1100);
    sel = 2'b10;
    edge_check("shl1", 4'b1001);
    edge_check("shl2", 4'b0011);
    sel = 2'b11;
    edge_check("load1", 4'b1011);
    edge_check("load2", 4'b1011);
    sel = 2'b01;
    edge_check("shr_after_load1", 4'b1101);
    edge_check("shr_after_load2", 4'b1110);
    sel = 2'b10;
    edge_check("shl_after_shr1", 4'b1101);
    edge_check("shl_after_shr2", 4'b1011);
    sel = 2'b00;
    edge_check("hold1", 4'b1011);
    edge_check("hold2", 4'b1011);
    edge_check("hold3", 4'b1011);
    #4;
    sel = 2'b11;
    in  = 4'b0100;
    #2;
    check("no_comb_path", 4'b1011);
    sel = 2'b00;
    in  = 4'b1011;
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", 4'b0000);
    sel = 2'b11;
    in  = 4'b0110;
    edge_check("edge_during_reset", 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("after_release", 4'b0000);
    edge_check("load_after_release", 4'b0110);
    sel = 2'b10;
    in  = 4'b0001;
    edge_check("shl_serial_in", 4'b1101);
    sel = 2'b01;
    in  = 4'b0000;
    edge_check("shr_serial_zero", 4'b0110);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/usr.md
Name: usr

Overview:
- Parameterised universal shift register: hold, shift right, shift left, or parallel load, selected by a 2-bit mode input.
- Generic datapath utility block, used wherever a small register needs serial or parallel update.
- Single clock domain.
- Default width of 4 bits.

Parameters:
- WIDTH, 4, register width in bits; legal when WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears the register.
- in  input  WIDTH  parallel load data; also supplies the serial input bits.
- sel  input  2  mode select (encoding under Behaviour).
- y  output  WIDTH  current register contents, driven directly from flops.

Interface decision: one clock (clk); reset rst is asynchronous and active-low.

Behaviour:
- Reset:
  - rst = 0 clears y to all zeros immediately, with no clock required.
  - While rst = 0, y stays zero and clock edges are ignored.
  - in and sel may be X during reset; y must not go X.
- After rst rises, the first rising clk edge performs the selected operation.
- Mode encoding, applied on each rising clk edge while rst = 1:
  - 00 HOLD: y unchanged.
  - 01 SHIFT RIGHT: y <= {in[WIDTH-1], y[WIDTH-1:1]}. The serial-in bit is the MSB of in; the LSB of y is discarded.
  - 10 SHIFT LEFT: y <= {y[WIDTH-2:0], in[0]}. The serial-in bit is the LSB of in; the MSB of y is discarded.
  - 11 LOAD: y <= in.
- Latency: one clock. The new y is visible after the rising edge that samples sel and in.
- Purely synchronous datapath. No combinational path from in or sel to y.
- A sel change between edges has no effect until the next rising edge.
- Reset asserted mid-operation: y clears immediately, regardless of sel.
- Release timing: rst release should not coincide with a rising clk edge. If it does, the bench accepts either zero or the operation's result on that edge.
- No handshake and no status flags. Every edge with rst = 1 is a valid operation.

Decomposition:
- Shared package usr_pkg:
  - Localparams for the sel encoding: SEL_HOLD = 2'b00, SEL_SHR = 2'b01, SEL_SHL = 2'b10, SEL_LOAD = 2'b11.
  - Default WIDTH constant.
- Optional sub-module usr_bit_cell, one per bit:
  - A 4:1 mux (hold / right neighbour / left neighbour / parallel bit) feeding a flop with async active-low clear.
  - Instantiated WIDTH times by a generate loop.
  - End bits take their serial inputs from in[WIDTH-1] and in[0].
- A flat single always-block implementation is equally acceptable.

Test Plan:
Clock has period 20, with rising edges at 10, 30, 50, … ns. Reset is held low until 12 ns; in = 4'b1011 throughout.
1. Reset: rst = 0 at time 0 with in and sel = X -> y = 0000 continuously until release; edge at 10 ns ignored.
2. Shift right from zero: sel = 01 for two edges (30, 50 ns) -> y = 1000, then 1100.
3. Shift left: sel = 10 for two edges (70, 90 ns) -> y = 1001, then 0011.
4. Load: sel = 11 for two edges (110, 130 ns) -> y = 1011 both times.
5. Shift right then left after load:
   - sel = 01 at 150 and 170 ns -> y = 1101, then 1110.
   - sel = 10 at 190 and 210 ns -> y = 1101, then 1011.
6. Hold and async reset:
   - From y = 1011, sel = 00 for 3 edges -> y stays 1011.
   - Drive rst low mid-cycle (not on an edge) -> y = 0000 before the next edge.
   - Release rst with sel = 11 and in = 0110 -> y = 0110 on the first edge.
